// File: rtl/skewed_transpose_bank.sv
// rtl/skewed_transpose_bank.sv - double-buffered CHxDEPTH transpose bank with per-channel skew
module skewed_transpose_bank #(
  parameter int DEPTH = 8,
  parameter int BITS  = 8,
  parameter int CH    = 8,
  parameter int SKEW  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [CH*DEPTH*BITS-1:0]  load_data,
  input  logic                      stall,
  output logic [CH*BITS-1:0]        q,
  output logic [CH-1:0]             q_valid,
  output logic                      busy,
  output logic                      done
);

  // Last drain step of a tile: the final element of the most-delayed channel.
  localparam int TLAST  = DEPTH - 1 + SKEW * (CH - 1);
  localparam int TW     = $clog2(TLAST + 1);
  localparam int TILE_W = CH * DEPTH * BITS;

  logic [TILE_W-1:0] active_q, active_d;
  logic [TILE_W-1:0] shadow_q, shadow_d;
  logic              active_full_q, active_full_d;
  logic              shadow_full_q, shadow_full_d;
  logic [TW-1:0]     t_q, t_d;

  logic step;
  logic last;
  logic accept;

  // Handshake and drain-progress qualifiers shared by next-state and outputs.
  always_comb begin
    step       = active_full_q && !stall;
    last       = (t_q == TW'(TLAST));
    done       = step && last;
    load_ready = !shadow_full_q;
    accept     = load_valid && load_ready;
    busy       = active_full_q;
  end

  // Next-state: drain counter, tile retirement, and load routing to active or shadow.
  always_comb begin
    active_d      = active_q;
    shadow_d      = shadow_q;
    active_full_d = active_full_q;
    shadow_full_d = shadow_full_q;
    t_d           = t_q;

    if (step) begin
      t_d = last ? '0 : t_q + TW'(1);
    end

    // Retiring tile: promote the waiting shadow tile, or go idle if nothing replaces it.
    if (done) begin
      if (shadow_full_q) begin
        active_d      = shadow_q;
        shadow_full_d = 1'b0;
      end else if (!accept) begin
        active_full_d = 1'b0;
      end
    end

    // An accepted tile starts immediately when the active bank is free or just freeing up;
    // accept already implies the shadow bank is empty.
    if (accept) begin
      if (!active_full_q || done) begin
        active_d      = load_data;
        active_full_d = 1'b1;
        t_d           = '0;
      end else begin
        shadow_d      = load_data;
        shadow_full_d = 1'b1;
      end
    end
  end

  // Output mux: channel c shows element t - SKEW*c while that index lies inside the tile.
  always_comb begin
    q       = '0;
    q_valid = '0;
    for (int c = 0; c < CH; c++) begin
      int e;
      e = int'(t_q) - SKEW * c;
      if (step && e >= 0 && e < DEPTH) begin
        q[c*BITS +: BITS] = active_q[(c*DEPTH + e)*BITS +: BITS];
        q_valid[c]        = 1'b1;
      end
    end
  end

  // State registers; reset discards both banks including any pending shadow tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q      <= '0;
      shadow_q      <= '0;
      active_full_q <= 1'b0;
      shadow_full_q <= 1'b0;
      t_q           <= '0;
    end else begin
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      active_full_q <= active_full_d;
      shadow_full_q <= shadow_full_d;
      t_q           <= t_d;
    end
  end

endmodule

// File: tb/tb_skewed_transpose_bank.sv
// tb/tb_skewed_transpose_bank.sv - self-checking bench for skewed_transpose_bank
module tb_skewed_transpose_bank;

  localparam int CH    = 4;
  localparam int DEPTH = 4;
  localparam int BITS  = 8;
  localparam int TLAST = DEPTH - 1 + (CH - 1);
  localparam int TW_   = CH * DEPTH * BITS;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_valid, stall;
  logic [TW_-1:0]    load_data;
  logic              load_ready, busy, done;
  logic [CH*BITS-1:0] q;
  logic [CH-1:0]     q_valid;

  logic              load_valid0, stall0;
  logic [TW_-1:0]    load_data0;
  logic              load_ready0, busy0, done0;
  logic [CH*BITS-1:0] q0;
  logic [CH-1:0]     q_valid0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  skewed_transpose_bank #(.DEPTH(DEPTH), .BITS(BITS), .CH(CH), .SKEW(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .stall(stall), .q(q), .q_valid(q_valid), .busy(busy), .done(done)
  );

  skewed_transpose_bank #(.DEPTH(DEPTH), .BITS(BITS), .CH(CH), .SKEW(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid0), .load_ready(load_ready0),
    .load_data(load_data0), .stall(stall0), .q(q0), .q_valid(q_valid0), .busy(busy0), .done(done0)
  );

  typedef struct {
    logic        st;
    logic        lv;
    logic [3:0]  qv;
    logic [31:0] qq;
    logic        dn;
    logic        bz;
    logic        rd;
  } vec_t;

  vec_t tbl[$];

  // Behavioural reference: a FIFO of at most two tiles, head being drained at step mt.
  logic [TW_-1:0] mq[$];
  int             mt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [TW_-1:0] pattern();
    logic [TW_-1:0] d;
    d = '0;
    for (int c = 0; c < CH; c++)
      for (int e = 0; e < DEPTH; e++)
        d[(c*DEPTH + e)*BITS +: BITS] = 8'(16*c + e);
    return d;
  endfunction

  function automatic logic [TW_-1:0] rnd_tile();
    logic [TW_-1:0] d;
    for (int i = 0; i < TW_/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic void add(input logic st, input logic lv, input logic [3:0] qv,
                              input logic [31:0] qq, input logic dn, input logic bz, input logic rd);
    vec_t v;
    v.st = st; v.lv = lv; v.qv = qv; v.qq = qq; v.dn = dn; v.bz = bz; v.rd = rd;
    tbl.push_back(v);
  endfunction

  // One model-checked cycle on the skewed DUT; called at posedge+1, returns at posedge+1.
  task automatic model_cycle(input logic st, input logic lv, input logic [TW_-1:0] d);
    logic [31:0] eq;
    logic [3:0]  eqv;
    logic        stp, dn, acc;
    stall = st; load_valid = lv; load_data = d;
    @(negedge clk);
    stp = (mq.size() > 0) && !st;
    dn  = stp && (mt == TLAST);
    acc = lv && (mq.size() < 2);
    eq = '0; eqv = '0;
    if (stp) begin
      for (int c = 0; c < CH; c++) begin
        int e;
        e = mt - c;
        if (e >= 0 && e < DEPTH) begin
          eq[c*BITS +: BITS] = mq[0][(c*DEPTH + e)*BITS +: BITS];
          eqv[c] = 1'b1;
        end
      end
    end
    chk("rand_q", 64'(q), 64'(eq));
    chk("rand_q_valid", 64'(q_valid), 64'(eqv));
    chk("rand_done", 64'(done), 64'(dn));
    chk("rand_busy", 64'(busy), 64'(mq.size() > 0));
    chk("rand_load_ready", 64'(load_ready), 64'(mq.size() < 2));
    @(posedge clk);
    if (dn) begin
      void'(mq.pop_front());
      mt = 0;
    end else if (stp) begin
      mt++;
    end
    if (acc) mq.push_back(d);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TW_-1:0] tiles[3];
    logic [TW_-1:0] pat;
    int idx, run, maxrun, a_done, c_acc, ready_low;
    logic acc;

    pat = pattern();

    // Single tile, no stall.
    add(0, 1, 4'h0, 32'h00000000, 0, 0, 1);
    add(0, 0, 4'h1, 32'h00000000, 0, 1, 1);
    add(0, 0, 4'h3, 32'h00001001, 0, 1, 1);
    add(0, 0, 4'h7, 32'h00201102, 0, 1, 1);
    add(0, 0, 4'hF, 32'h30211203, 0, 1, 1);
    add(0, 0, 4'hE, 32'h31221300, 0, 1, 1);
    add(0, 0, 4'hC, 32'h32230000, 0, 1, 1);
    add(0, 0, 4'h8, 32'h33000000, 1, 1, 1);
    add(0, 0, 4'h0, 32'h00000000, 0, 0, 1);
    // Three-cycle stall at t=2; done lands in the 10th cycle after load.
    add(0, 1, 4'h0, 32'h00000000, 0, 0, 1);
    add(0, 0, 4'h1, 32'h00000000, 0, 1, 1);
    add(0, 0, 4'h3, 32'h00001001, 0, 1, 1);
    add(1, 0, 4'h0, 32'h00000000, 0, 1, 1);
    add(1, 0, 4'h0, 32'h00000000, 0, 1, 1);
    add(1, 0, 4'h0, 32'h00000000, 0, 1, 1);
    add(0, 0, 4'h7, 32'h00201102, 0, 1, 1);
    add(0, 0, 4'hF, 32'h30211203, 0, 1, 1);
    add(0, 0, 4'hE, 32'h31221300, 0, 1, 1);
    add(0, 0, 4'hC, 32'h32230000, 0, 1, 1);
    add(0, 0, 4'h8, 32'h33000000, 1, 1, 1);
    add(0, 0, 4'h0, 32'h00000000, 0, 0, 1);
    // Load while stalled and idle; drain starts at t=0 on release.
    add(1, 1, 4'h0, 32'h00000000, 0, 0, 1);
    add(1, 0, 4'h0, 32'h00000000, 0, 1, 1);
    add(0, 0, 4'h1, 32'h00000000, 0, 1, 1);
    add(0, 0, 4'h3, 32'h00001001, 0, 1, 1);
    add(0, 0, 4'h7, 32'h00201102, 0, 1, 1);
    add(0, 0, 4'hF, 32'h30211203, 0, 1, 1);
    add(0, 0, 4'hE, 32'h31221300, 0, 1, 1);
    add(0, 0, 4'hC, 32'h32230000, 0, 1, 1);
    add(0, 0, 4'h8, 32'h33000000, 1, 1, 1);
    add(0, 0, 4'h0, 32'h00000000, 0, 0, 1);

    rst_n = 1'b0;
    load_valid = 0; stall = 0; load_data = '0;
    load_valid0 = 0; stall0 = 0; load_data0 = '0;
    #2;
    chk("reset_q", 64'(q), 64'h0);
    chk("reset_q_valid", 64'(q_valid), 64'h0);
    chk("reset_done", 64'(done), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_load_ready", 64'(load_ready), 64'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table-driven directed vectors on the SKEW=1 instance.
    foreach (tbl[i]) begin
      stall = tbl[i].st; load_valid = tbl[i].lv; load_data = pat;
      @(negedge clk);
      chk($sformatf("tbl%0d_q", i), 64'(q), 64'(tbl[i].qq));
      chk($sformatf("tbl%0d_q_valid", i), 64'(q_valid), 64'(tbl[i].qv));
      chk($sformatf("tbl%0d_done", i), 64'(done), 64'(tbl[i].dn));
      chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].bz));
      chk($sformatf("tbl%0d_load_ready", i), 64'(load_ready), 64'(tbl[i].rd));
      @(posedge clk); #1;
    end
    stall = 0; load_valid = 0;

    // Back-to-back tiles A, B, C offered continuously.
    tiles[0] = pat; tiles[1] = rnd_tile(); tiles[2] = rnd_tile();
    idx = 0; run = 0; maxrun = 0; a_done = -1; c_acc = -1; ready_low = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      load_valid = (idx < 3);
      load_data  = (idx < 3) ? tiles[idx] : '0;
      @(negedge clk);
      if (q_valid != 0) begin
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      if (a_done >= 0 && cyc == a_done + 1) begin
        chk("b2b_b_t0_q_valid", 64'(q_valid), 64'h1);
        chk("b2b_b_t0_ch0", 64'(q[7:0]), 64'(tiles[1][7:0]));
      end
      if (done && a_done < 0) a_done = cyc;
      if (!load_ready && idx == 2) ready_low++;
      acc = load_valid && load_ready;
      @(posedge clk); #1;
      if (acc) begin
        if (idx == 2) c_acc = cyc;
        idx++;
      end
    end
    load_valid = 0;
    chk("b2b_a_done_cycle", 64'(a_done), 64'd7);
    chk("b2b_c_accept_cycle", 64'(c_acc), 64'd8);
    chk("b2b_ready_low_cycles", 64'(ready_low), 64'd6);
    chk("b2b_contiguous_valid", 64'(maxrun), 64'd21);

    // SKEW=0 instance: all channels aligned, done at t=3.
    load_valid0 = 1; load_data0 = pat;
    @(negedge clk);
    chk("noskew_ready", 64'(load_ready0), 64'h1);
    @(posedge clk); #1;
    load_valid0 = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk($sformatf("noskew_t%0d_q_valid", i), 64'(q_valid0), 64'hF);
      chk($sformatf("noskew_t%0d_done", i), 64'(done0), 64'(i == DEPTH - 1));
      if (i == DEPTH - 1) chk("noskew_t3_q", 64'(q0), 64'h33231303);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("noskew_idle_busy", 64'(busy0), 64'h0);
    @(posedge clk); #1;

    // Async reset at t=3 with the shadow bank full.
    mq.delete(); mt = 0;
    tiles[0] = rnd_tile(); tiles[1] = rnd_tile(); tiles[2] = rnd_tile();
    model_cycle(0, 1, tiles[0]);
    model_cycle(0, 1, tiles[1]);
    model_cycle(0, 0, '0);
    model_cycle(0, 0, '0);
    chk("pre_reset_shadow_full", 64'(load_ready), 64'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_q", 64'(q), 64'h0);
    chk("async_rst_q_valid", 64'(q_valid), 64'h0);
    chk("async_rst_busy", 64'(busy), 64'h0);
    chk("async_rst_load_ready", 64'(load_ready), 64'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mq.delete(); mt = 0;
    model_cycle(0, 1, tiles[2]);
    for (int i = 0; i < TLAST + 3; i++) model_cycle(0, 0, '0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      model_cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), rnd_tile());
    end
    for (int i = 0; i < 3 * (TLAST + 1); i++) model_cycle(0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/skewed_transpose_bank.md
# skewed_transpose_bank

Multi-channel, double-buffered transpose buffer that feeds the systolic array edge. It accepts a full CH×DEPTH tile in one handshake and replays each channel's DEPTH elements serially, one per cycle. Channel c is delayed by c cycles when skew is enabled, producing the diagonal wavefront the array needs. A shadow bank allows back-to-back tiles with no bubble. It supports stall-hold, per-channel valid, and a tile-done pulse.

## Interface
- DEPTH, 8, elements per channel per tile (≥2)
- BITS, 8, element width
- CH, 8, channel count (≥1)
- SKEW, 1, 1 = channel c delayed c cycles; 0 = all channels aligned
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low; clears all state immediately
- load_valid  in  1  tile present on load_data
- load_ready  out  1  tile accepted at an edge where load_valid && load_ready
- load_data  in  CH*DEPTH*BITS  channel c element e at bits [(c*DEPTH+e)*BITS +: BITS]; element 0 emitted first
- stall  in  1  freeze drain; outputs forced to zero
- q  out  CH*BITS  channel c output at [c*BITS +: BITS]
- q_valid  out  CH  per-channel element-valid
- busy  out  1  active bank holds a tile
- done  out  1  high during the final emit cycle of a tile

## Operation
- State:
  - active bank (CH×DEPTH×BITS) plus active_full flag.
  - shadow bank plus shadow_full flag.
  - drain counter t of width clog2(TLAST+1), where TLAST = DEPTH-1 + SKEW*(CH-1).
- Channel c emits element e = t - SKEW*c when 0 ≤ e < DEPTH.
  - q[c] = active[c][e], q_valid[c] = 1.
  - Otherwise q[c] = 0, q_valid[c] = 0.
- q, q_valid and done are combinational from registered state. They are all zero when stall=1 or active_full=0.
- step = active_full && !stall. On step: t increments. At t==TLAST, t returns to 0 and the tile retires.
- done = step && t==TLAST.
- load_ready = !shadow_full. It is independent of stall and of load_valid.
- Accepted load, routed at the same edge:
  - It goes directly to the active bank (t=0) if active_full=0, or if done=1 and shadow_full=0.
  - Otherwise it goes to the shadow bank, and shadow_full is set.
- Retire with shadow_full=1: shadow is copied to active, t=0, shadow_full is cleared, active_full stays 1.
- Retire with shadow_full=0 and no accepted load: active_full is cleared.
- busy = active_full.

## Timing
- Reset values: q=0, q_valid=0, done=0, busy=0, load_ready=1, t=0, both banks zeroed.
- Load-to-first-output latency: tile accepted at edge N → element 0 of channel 0 on q during the cycle after N (active idle, no stall).
- Tile occupies TLAST+1 unstalled cycles. Back-to-back tiles run with zero idle cycles between them.
- Stall holds t and both banks. Each stalled cycle adds exactly one cycle to the tile duration.
- Load during stall is accepted per the routing rules. Draining does not begin until stall=0.
- Shadow full + active retiring at the same edge: load_ready is 0 that cycle; it rises the cycle after promotion.
- rst_n assertion mid-tile: all outputs go to reset values with no clock edge. Any pending shadow tile is discarded.

## Test plan
Config for scenarios 1, 2, 3, 5, 6: CH=4, DEPTH=4, BITS=8, SKEW=1, so TLAST=6. Tile element (c,e) = 16c+e.
- Single tile, no stall:
  - t=0 → q_valid=0001, ch0=0x00.
  - t=1 → q_valid=0011, ch0=0x01, ch1=0x10.
  - t=3 → q_valid=1111, ch0..ch3 = 0x03, 0x12, 0x21, 0x30.
  - t=6 → q_valid=1000, ch3=0x33, done=1.
  - Next cycle → busy=0.
- stall=1 for 3 cycles starting at t=2:
  - Those cycles → q=0, q_valid=0000.
  - Resume → ch0=0x02, ch1=0x11, ch2=0x20.
  - done in the 10th cycle after load.
- Tiles A, B, C offered back-to-back:
  - B lands in shadow, load_ready drops, C is held.
  - B t=0 appears the cycle after A's done, with no gap.
  - C is accepted the cycle after B is promoted.
  - Result: 21 contiguous cycles with q_valid≠0.
- SKEW=0, same tile:
  - 4 cycles with q_valid=1111; at t=3 ch0..ch3 = 0x03, 0x13, 0x23, 0x33.
  - done=1 at t=3.
- Async reset at t=3 with shadow full:
  - Immediately → q=0, q_valid=0, busy=0, load_ready=1.
  - Next tile starts at t=0 with its own data; no shadow data leaks.
- Load during stall with bank idle:
  - Accepted with busy=1, outputs zero.
  - After stall release, first output is t=0 (ch0=0x00).
